// File: rtl/seg7_keypad_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_keypad_scan_display
// Time-multiplexed N-digit 7-segment driver for the matrix-keypad path.
// Holds the last N_DIGITS key codes in a shift buffer, decodes each to a
// glyph and scans one digit at a time. Each digit slot starts with a short
// blanking gap (all anodes off) so the previous digit's segment pattern
// cannot ghost onto the next digit while the drivers settle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    1-cycle strobe, key_code holds a new key
//   key_code     key index, row-major 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
//   clear        empty the buffer (wins over a simultaneous key_valid)
//   seg          {g,f,e,d,c,b,a}, active low
//   anode        one-hot active-low digit enable, digit 0 = rightmost
//   digit_count  number of valid digits, saturates at N_DIGITS
// ---------------------------------------------------------------------------
module seg7_keypad_scan_display #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  input  logic                              clear,
  output logic [6:0]                        seg,
  output logic [N_DIGITS-1:0]               anode,
  output logic [$clog2(N_DIGITS+1)-1:0]     digit_count
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW = $clog2(N_DIGITS + 1);

  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [DW-1:0] COUNT_MAX = DW'(N_DIGITS);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  logic [CW-1:0]       slot_cnt;
  logic [IW-1:0]       digit_idx;
  logic [N_DIGITS-1:0] entry_valid;
  logic [3:0]          entry_code [N_DIGITS];

  logic                blank;
  logic [6:0]          seg_next;
  logic [N_DIGITS-1:0] anode_next;

  // Key index to active-low segment pattern, row-major keypad order.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'h79;  // 1
      4'd1:    g = 7'h24;  // 2
      4'd2:    g = 7'h30;  // 3
      4'd3:    g = 7'h08;  // A
      4'd4:    g = 7'h19;  // 4
      4'd5:    g = 7'h12;  // 5
      4'd6:    g = 7'h02;  // 6
      4'd7:    g = 7'h03;  // b
      4'd8:    g = 7'h78;  // 7
      4'd9:    g = 7'h00;  // 8
      4'd10:   g = 7'h10;  // 9
      4'd11:   g = 7'h46;  // C
      4'd12:   g = 7'h3F;  // * shown as a dash
      4'd13:   g = 7'h40;  // 0
      4'd14:   g = 7'h36;  // #
      default: g = 7'h21;  // d
    endcase
    return g;
  endfunction

  // Slot counter and digit index. The index only advances on the slot
  // wrap, so a digit is never swapped in the middle of its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // Key buffer: a new key enters at digit 0 and pushes older keys left,
  // dropping the oldest. clear takes priority so a key arriving in the
  // same cycle is discarded rather than landing in an emptied buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= '0;
      digit_count <= '0;
      for (int i = 0; i < N_DIGITS; i++) entry_code[i] <= '0;
    end else if (clear) begin
      entry_valid <= '0;
      digit_count <= '0;
    end else if (key_valid) begin
      for (int i = N_DIGITS - 1; i > 0; i--) begin
        entry_code[i]  <= entry_code[i-1];
        entry_valid[i] <= entry_valid[i-1];
      end
      entry_code[0]  <= key_code;
      entry_valid[0] <= 1'b1;
      if (digit_count != COUNT_MAX) digit_count <= digit_count + 1'b1;
    end
  end

  // Next display value from the current counter, index and buffer.
  always_comb begin
    blank      = (slot_cnt < BLANK_END);
    seg_next   = SEG_BLANK;
    anode_next = '1;
    if (!blank) begin
      anode_next[digit_idx] = 1'b0;
      if (entry_valid[digit_idx]) seg_next = glyph(entry_code[digit_idx]);
    end
  end

  // Registered display drivers, forced dark straight away on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_BLANK;
      anode <= '1;
    end else begin
      seg   <= seg_next;
      anode <= anode_next;
    end
  end

endmodule

// File: tb/tb_seg7_keypad_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_keypad_scan_display
// Directed bench for seg7_keypad_scan_display with N_DIGITS=4,
// REFRESH_DIV=8, BLANK_CYC=2. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_seg7_keypad_scan_display;

  localparam int N_DIGITS    = 4;
  localparam int REFRESH_DIV = 8;
  localparam int BLANK_CYC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic [3:0] anode;
  logic [2:0] digit_count;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] code;
    logic [6:0] glyph;
  } vec_t;

  vec_t vecs [16];

  seg7_keypad_scan_display #(
    .N_DIGITS   (N_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .clear      (clear),
    .seg        (seg),
    .anode      (anode),
    .digit_count(digit_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison; reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive inputs for exactly one clock cycle, starting at a falling edge.
  task automatic applyStimulus(input logic kv, input logic [3:0] kc, input logic clr);
    key_valid = kv;
    key_code  = kc;
    clear     = clr;
    @(negedge clk);
    key_valid = 1'b0;
    clear     = 1'b0;
  endtask

  // Reset for two cycles, release on a falling edge.
  task automatic doReset();
    key_valid = 1'b0;
    clear     = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) until the given digit is lit, then compare seg.
  task automatic checkDigit(input int d, input logic [6:0] expected, input string name);
    logic [3:0] target;
    bit found;
    target    = 4'b1111;
    target[d] = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (anode == target) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({name, " digit lit"}, {31'd0, found}, 32'd1);
    if (found) checkOutput(name, {25'd0, seg}, {25'd0, expected});
  endtask

  initial begin
    logic [3:0] exp_anode;
    int         slot_pos;
    int         slot_idx;

    vecs[0]  = '{4'd0,  7'h79};
    vecs[1]  = '{4'd1,  7'h24};
    vecs[2]  = '{4'd2,  7'h30};
    vecs[3]  = '{4'd3,  7'h08};
    vecs[4]  = '{4'd4,  7'h19};
    vecs[5]  = '{4'd5,  7'h12};
    vecs[6]  = '{4'd6,  7'h02};
    vecs[7]  = '{4'd7,  7'h03};
    vecs[8]  = '{4'd8,  7'h78};
    vecs[9]  = '{4'd9,  7'h00};
    vecs[10] = '{4'd10, 7'h10};
    vecs[11] = '{4'd11, 7'h46};
    vecs[12] = '{4'd12, 7'h3F};
    vecs[13] = '{4'd13, 7'h40};
    vecs[14] = '{4'd14, 7'h36};
    vecs[15] = '{4'd15, 7'h21};

    // Reset state and the empty scan pattern for 40 cycles.
    @(negedge clk);
    doReset();
    checkOutput("reset anode", {28'd0, anode}, 32'hF);
    checkOutput("reset seg", {25'd0, seg}, 32'h7F);
    checkOutput("reset count", {29'd0, digit_count}, 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      slot_pos  = (k - 1) % REFRESH_DIV;
      slot_idx  = ((k - 1) / REFRESH_DIV) % N_DIGITS;
      exp_anode = 4'b1111;
      if (slot_pos >= BLANK_CYC) exp_anode[slot_idx] = 1'b0;
      checkOutput($sformatf("scan anode c%0d", k), {28'd0, anode}, {28'd0, exp_anode});
      checkOutput($sformatf("scan seg c%0d", k), {25'd0, seg}, 32'h7F);
    end

    // Every key code through digit 0, with saturation of the count.
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].code, 1'b0);
      checkDigit(0, vecs[i].glyph, $sformatf("glyph key %0d", i));
      checkOutput($sformatf("count after %0d keys", i + 1), {29'd0, digit_count},
                  (i + 1 < N_DIGITS) ? i + 1 : N_DIGITS);
    end

    // Keys "1" then "0".
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd13, 1'b0);
    checkDigit(0, 7'h40, "two keys d0");
    checkDigit(1, 7'h79, "two keys d1");
    checkDigit(2, 7'h7F, "two keys d2");
    checkDigit(3, 7'h7F, "two keys d3");
    checkOutput("two keys count", {29'd0, digit_count}, 32'd2);

    // Six keys 0..5: only the last four (codes 2,3,4,5) survive.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'(i), 1'b0);
    checkDigit(3, 7'h30, "six keys d3");
    checkDigit(2, 7'h08, "six keys d2");
    checkDigit(1, 7'h19, "six keys d1");
    checkDigit(0, 7'h12, "six keys d0");
    checkOutput("six keys count", {29'd0, digit_count}, 32'd4);

    // clear together with key_valid: clear wins and the key is lost.
    applyStimulus(1'b1, 4'd9, 1'b1);
    checkOutput("clear count", {29'd0, digit_count}, 32'd0);
    for (int d = 0; d < N_DIGITS; d++)
      checkDigit(d, 7'h7F, $sformatf("clear d%0d", d));
    applyStimulus(1'b1, 4'd9, 1'b0);
    checkOutput("key after clear count", {29'd0, digit_count}, 32'd1);
    checkDigit(0, 7'h00, "key after clear d0");

    // Asynchronous reset while digit 2 is lit.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd1, 1'b0);
    applyStimulus(1'b1, 4'd2, 1'b0);
    checkDigit(2, 7'h79, "pre-reset d2");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset anode", {28'd0, anode}, 32'hF);
    checkOutput("async reset seg", {25'd0, seg}, 32'h7F);
    checkOutput("async reset count", {29'd0, digit_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("restart blank 1", {28'd0, anode}, 32'hF);
    @(negedge clk);
    checkOutput("restart blank 2", {28'd0, anode}, 32'hF);
    @(negedge clk);
    checkOutput("restart digit 0", {28'd0, anode}, 32'hE);
    checkOutput("restart seg", {25'd0, seg}, 32'h7F);

    // Key arriving while digit 0 is lit shows up exactly two cycles later.
    doReset();
    repeat (3) @(negedge clk);
    checkOutput("live d0 lit", {28'd0, anode}, 32'hE);
    key_valid = 1'b1;
    key_code  = 4'd7;
    @(negedge clk);
    key_valid = 1'b0;
    checkOutput("live +1 seg", {25'd0, seg}, 32'h7F);
    checkOutput("live +1 anode", {28'd0, anode}, 32'hE);
    @(negedge clk);
    checkOutput("live +2 seg", {25'd0, seg}, 32'h03);
    checkOutput("live +2 anode", {28'd0, anode}, 32'hE);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
